// File: rtl/irq_controller_pkg.sv
// Shared register map, vector encoding and FSM state type for the interrupt controller.
package irq_controller_pkg;

  localparam logic [63:0] OFF_PENDING = 64'h00;
  localparam logic [63:0] OFF_ENABLE  = 64'h08;
  localparam logic [63:0] OFF_CLAIM   = 64'h10;

  localparam int unsigned VEC_NONE = 0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESENT      = 2'd1,
    WAIT_RELEASE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer with rising-edge detection for a vector of asynchronous requests.
module irq_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;
  logic [1:0]   warm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      warm_q <= 2'd0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // A level already high at reset release must not look like an edge, so
  // detection stays off until the history register holds a real sample.
  assign sync = sync_q;
  assign rise = sync_q & ~prev_q & {W{warm_q == 2'd3}};

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: pending/enable registers, fixed priority and a
// present/acknowledge handshake toward the CPU.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int                 NUM_SRC   = 8,
  parameter int                 VEC_W     = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MODE = '1,
  parameter logic [63:0]        BASE      = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [63:0]        bus_address,
  input  logic [63:0]        bus_write_data,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  output logic [63:0]        bus_read_data,
  output logic [VEC_W-1:0]   interrupt_vector,
  input  logic               interrupt_ack
);

  localparam logic [63:0]      ADDR_PENDING = BASE + OFF_PENDING;
  localparam logic [63:0]      ADDR_ENABLE  = BASE + OFF_ENABLE;
  localparam logic [63:0]      ADDR_CLAIM   = BASE + OFF_CLAIM;
  localparam logic [VEC_W-1:0] VEC_IDLE     = VEC_W'(VEC_NONE);

  logic [NUM_SRC-1:0] src_sync;
  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] ack_mask;
  logic [NUM_SRC-1:0] lat_oh;
  logic [VEC_W-1:0]   cand_idx;
  logic               cand_vld;
  logic [VEC_W-1:0]   vec_d;
  logic [63:0]        rd_d;
  irq_state_e         state_q;
  irq_state_e         state_d;
  logic               wdata_unused;

  assign wdata_unused = ^bus_write_data[63:NUM_SRC];

  irq_sync_edge #(
    .W (NUM_SRC)
  ) u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .din   (irq_src),
    .sync  (src_sync),
    .rise  (src_rise)
  );

  assign w1c_mask = (bus_write_enable && (bus_address == ADDR_PENDING))
                    ? bus_write_data[NUM_SRC-1:0] : '0;

  // Edge bits: a new edge beats any clear in the same cycle. Level bits follow the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      enable  <= '0;
    end else begin
      pending <= (EDGE_MODE & ((pending & ~(w1c_mask | ack_mask)) | src_rise))
               | (~EDGE_MODE & src_sync);
      if (bus_write_enable && (bus_address == ADDR_ENABLE))
        enable <= bus_write_data[NUM_SRC-1:0];
    end
  end

  always_comb begin
    rd_d = '0;
    if (bus_address == ADDR_PENDING)      rd_d[NUM_SRC-1:0] = pending;
    else if (bus_address == ADDR_ENABLE)  rd_d[NUM_SRC-1:0] = enable;
    else if (bus_address == ADDR_CLAIM)   rd_d[VEC_W-1:0]   = interrupt_vector;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                bus_read_data <= '0;
    else if (bus_read_enable) bus_read_data <= rd_d;
  end

  assign active = pending & enable;

  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        cand_vld = 1'b1;
        cand_idx = VEC_W'(i);
      end
    end
  end

  // While presenting, the vector register itself identifies the latched source.
  assign lat_oh = NUM_SRC'(1) << (interrupt_vector - VEC_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      interrupt_vector <= VEC_IDLE;
    end else begin
      state_q          <= state_d;
      interrupt_vector <= vec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = interrupt_vector;
    ack_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (cand_vld) begin
          vec_d   = cand_idx + VEC_W'(1);
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (interrupt_ack) begin
          ack_mask = EDGE_MODE & lat_oh;
          vec_d    = VEC_IDLE;
          state_d  = WAIT_RELEASE;
        end else if (~|(enable & lat_oh)) begin
          vec_d   = VEC_IDLE;
          state_d = IDLE;
        end
      end
      WAIT_RELEASE: begin
        if (!interrupt_ack) state_d = IDLE;
      end
      default: begin
        vec_d   = VEC_IDLE;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources (1..15).
REQ-002 Parameter VEC_W, default 4, vector width; SHALL satisfy 2**VEC_W > NUM_SRC.
REQ-003 Parameter EDGE_MODE, default all-ones [NUM_SRC-1:0], per-source type: 1 = rising-edge, 0 = level-high.
REQ-004 Parameter BASE, default 64'h0, bus base address of the register block.
REQ-005 Port clk  input  1  single clock, all logic on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port irq_src  input  NUM_SRC  raw asynchronous interrupt requests.
REQ-008 Port bus_address  input  64  byte address.
REQ-009 Port bus_write_data  input  64  write data.
REQ-010 Port bus_write_enable  input  1  write strobe, one cycle per access.
REQ-011 Port bus_read_enable  input  1  read strobe, one cycle per access.
REQ-012 Port bus_read_data  output  64  registered read data.
REQ-013 Port interrupt_vector  output  VEC_W  source index+1 presented to CPU; 0 = none.
REQ-014 Port interrupt_ack  input  1  CPU acknowledge of presented vector.

Function
REQ-015 Each irq_src bit SHALL pass a 2-flop synchronizer; edge detect compares the synchronized value with its previous value.
REQ-016 Edge source: pending bit set on synchronized 0->1; level source: pending bit equals synchronized level each cycle.
REQ-017 Registers at BASE+0x00 PENDING (RO; write-1-to-clear edge bits), BASE+0x08 ENABLE (RW, reset 0), BASE+0x10 CLAIM (RO, current vector), unused bits read 0; other addresses not decoded.
REQ-018 Read data SHALL appear on bus_read_data the cycle after bus_read_enable and hold until the next read; writes take effect the cycle after bus_write_enable.
REQ-019 Candidate = lowest-index bit of (PENDING & ENABLE); index 0 has highest priority; vector = index+1.
REQ-020 FSM states IDLE, PRESENT, WAIT_RELEASE.
REQ-021 IDLE: candidate exists -> latch vector, drive interrupt_vector next cycle, go PRESENT.
REQ-022 PRESENT: vector held stable regardless of new higher-priority pending; interrupt_ack=1 -> clear pending of latched source (edge type only), interrupt_vector <= 0, go WAIT_RELEASE.
REQ-023 PRESENT: if latched source loses ENABLE before ack, vector <= 0, return IDLE without clearing pending.
REQ-024 WAIT_RELEASE: remain until interrupt_ack=0, then IDLE; no vector presented while waiting.
REQ-025 Same-cycle set and clear (edge arrival vs. ack clear or W1C) on one bit: set wins, pending stays 1.
REQ-026 interrupt_ack while IDLE or WAIT_RELEASE SHALL be ignored.
REQ-027 Level source acked while still high SHALL be re-presented after WAIT_RELEASE.

Reset
REQ-028 reset SHALL clear synchronizers, edge history, PENDING, ENABLE, bus_read_data, interrupt_vector to 0 and force FSM to IDLE asynchronously.
REQ-029 Reset mid-PRESENT SHALL drop interrupt_vector to 0 without waiting for a clock.
REQ-030 After reset deassertion, a source already high SHALL NOT generate an edge (history starts at 0 only after 2 synchronized cycles show the level; first rising transition observed after reset counts).

Structure
REQ-031 Shared package holds register offsets (0x00/0x08/0x10), VEC_NONE = 0 and FSM state encoding.
REQ-032 One sub-module irq_sync_edge (synchronizer + rising-edge detect, width parameter) instantiated once for all sources.
REQ-033 Priority encoder and FSM remain in irq_controller.

Verification
REQ-034 ENABLE=0x06, pulse irq_src[2] -> vector 3 within 4 cycles; ack 1 cycle -> vector 0, PENDING bit2=0.
REQ-035 irq_src[1] and [3] rise same cycle, ENABLE=0xFF -> vector 2 first, after ack/release vector 4.
REQ-036 Level source 5 (EDGE_MODE bit5=0) held high through ack -> vector 6 re-presented after ack drops.
REQ-037 Edge on src0 same cycle as W1C write of bit0 to PENDING -> PENDING reads 0x01.
REQ-038 Reset asserted while vector=3 -> vector 0 same cycle, ENABLE reads 0 after release.
REQ-039 Hold ack high across new pending edge -> no vector until ack low, then vector presented.
